debounce_sync: RTL and testbench

Conditions an asynchronous, bouncing switch or push-button level into a clean, single-clock-domain level plus one-cycle edge pulses. Its `d_out` drives the `d` input of the lab flip-flop and register stages directly. Built as a two-flop synchronizer, a stability counter and a four-state FSM, so contact bounce and sub-threshold glitches never reach downstream storage elements.

---
 rtl/debounce_sync_pkg.sv | 15 +
 rtl/debounce_sync_sync_2ff.sv | 22 ++
 rtl/debounce_sync.sv | 104 ++++++++++
 tb/tb_debounce_sync.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/debounce_sync_pkg.sv
// Shared definitions for the switch debouncer: FSM state encodings and
// default qualification parameters.
package debounce_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LOW  = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_IDLE_HIGH = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    localparam int unsigned DEF_STABLE_CYCLES = 4;
    localparam int unsigned DEF_CNT_W         = 3;

endpackage

// File: rtl/debounce_sync_sync_2ff.sv
// Two-stage synchronizer bringing an asynchronous level into the clk domain.
// Kept standalone so other switch-sampling blocks can reuse it.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic y
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            y  <= 1'b0;
        end else begin
            s1 <= a;
            y  <= s1;
        end
    end

endmodule

// File: rtl/debounce_sync.sv
// Switch debouncer: synchronizer, stability counter and four-state FSM that
// produces a registered clean level plus one-cycle rise/fall pulses.
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic d_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             d_nxt, rise_nxt, fall_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .a   (raw_in),
        .y   (s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE_LOW;
            cnt        <= '0;
            d_out      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            d_out      <= d_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

    // Any reversal of s inside a WAIT state abandons qualification and
    // clears the counter, so cnt can never run past LAST.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        d_nxt     = d_out;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            ST_IDLE_LOW: begin
                if (s) begin
                    state_nxt = ST_WAIT_HIGH;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!s) begin
                    state_nxt = ST_IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = ST_IDLE_HIGH;
                    cnt_nxt   = '0;
                    d_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_IDLE_HIGH: begin
                if (!s) begin
                    state_nxt = ST_WAIT_LOW;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (s) begin
                    state_nxt = ST_IDLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = ST_IDLE_LOW;
                    cnt_nxt   = '0;
                    d_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == ST_WAIT_HIGH) || (state == ST_WAIT_LOW);

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: stimulus pushes hand-computed per-edge
// expectations; a negedge monitor pops and compares them.
module tb_debounce_sync;

    localparam int END_EDGE = 75;

    logic clk = 1'b0;
    logic rst;
    logic raw_in;
    logic d_out, rise_pulse, fall_pulse, busy;

    typedef struct {
        int         e;
        logic [3:0] v;    // {d_out, rise_pulse, fall_pulse, busy}
        string      nm;
    } exp_t;

    exp_t q[$];
    int   edge_n = 0;
    int   tests  = 0;
    int   fails  = 0;

    debounce_sync #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .d_out      (d_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void exp_one(input int e, input logic d, input logic r,
                                    input logic f, input logic b, input string nm);
        exp_t x;
        x.e  = e;
        x.v  = {d, r, f, b};
        x.nm = nm;
        q.push_back(x);
    endfunction

    function automatic void exp_rng(input int a, input int z, input logic d,
                                    input logic b, input string nm);
        for (int i = a; i <= z; i++) exp_one(i, d, 1'b0, 1'b0, b, nm);
    endfunction

    task automatic at_edge(input int e);
        do @(negedge clk); while (edge_n < e);
    endtask

    // Monitor: compares every expected edge, flags any unexpected pulse.
    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0 && q[0].e == edge_n) begin
            x = q.pop_front();
            tests++;
            if ({d_out, rise_pulse, fall_pulse, busy} !== x.v) begin
                fails++;
                $display("FAIL %s edge %0d: d/rise/fall/busy got %b required %b",
                         x.nm, edge_n, {d_out, rise_pulse, fall_pulse, busy}, x.v);
            end
        end else if (rise_pulse || fall_pulse) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse edge %0d: rise=%b fall=%b required 0/0",
                     edge_n, rise_pulse, fall_pulse);
        end
        if (edge_n >= END_EDGE) begin
            tests++;
            if (q.size() != 0) begin
                fails++;
                $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        rst    = 1'b1;
        raw_in = 1'b1;
        exp_rng(1, 3, 1'b0, 1'b0, "reset");

        at_edge(3);
        rst    = 1'b0;
        raw_in = 1'b0;
        exp_rng(4, 9, 1'b0, 1'b0, "idle_low");

        at_edge(9);
        raw_in = 1'b1;
        exp_rng(10, 11, 1'b0, 1'b0, "rise_sync");
        exp_rng(12, 15, 1'b0, 1'b1, "rise_wait");
        exp_one(16, 1'b1, 1'b1, 1'b0, 1'b0, "rise_accept");
        exp_rng(17, 19, 1'b1, 1'b0, "idle_high");

        at_edge(20);
        raw_in = 1'b0;
        exp_rng(21, 22, 1'b1, 1'b0, "fall_sync");
        exp_rng(23, 26, 1'b1, 1'b1, "fall_wait");
        exp_one(27, 1'b0, 1'b0, 1'b1, 1'b0, "fall_accept");
        exp_rng(28, 29, 1'b0, 1'b0, "after_fall");

        at_edge(30);
        raw_in = 1'b1;
        exp_rng(31, 32, 1'b0, 1'b0, "glitch_sync");
        exp_rng(33, 35, 1'b0, 1'b1, "glitch_wait");
        exp_rng(36, 39, 1'b0, 1'b0, "glitch_reject");
        at_edge(33);
        raw_in = 1'b0;

        at_edge(40);
        raw_in = 1'b1;
        exp_rng(41, 42, 1'b0, 1'b0, "bounce_sync");
        exp_one(43, 1'b0, 1'b0, 1'b0, 1'b1, "bounce_w1");
        exp_one(44, 1'b0, 1'b0, 1'b0, 1'b0, "bounce_i1");
        exp_one(45, 1'b0, 1'b0, 1'b0, 1'b1, "bounce_w2");
        exp_one(46, 1'b0, 1'b0, 1'b0, 1'b0, "bounce_i2");
        exp_rng(47, 50, 1'b0, 1'b1, "bounce_wait");
        exp_one(51, 1'b1, 1'b1, 1'b0, 1'b0, "bounce_accept");
        exp_rng(52, 53, 1'b1, 1'b0, "bounce_high");
        at_edge(41);
        raw_in = 1'b0;
        at_edge(42);
        raw_in = 1'b1;
        at_edge(43);
        raw_in = 1'b0;
        at_edge(44);
        raw_in = 1'b1;

        at_edge(54);
        rst = 1'b1;
        exp_one(55, 1'b0, 1'b0, 1'b0, 1'b0, "reset_in_high");

        at_edge(55);
        rst    = 1'b0;
        raw_in = 1'b0;
        exp_rng(56, 60, 1'b0, 1'b0, "midq_idle");
        exp_rng(61, 62, 1'b0, 1'b1, "midq_wait");
        exp_one(63, 1'b0, 1'b0, 1'b0, 1'b0, "midq_reset");
        at_edge(58);
        raw_in = 1'b1;
        at_edge(62);
        rst = 1'b1;

        at_edge(63);
        rst = 1'b0;
        exp_rng(64, 65, 1'b0, 1'b0, "post_rst_sync");
        exp_rng(66, 69, 1'b0, 1'b1, "post_rst_wait");
        exp_one(70, 1'b1, 1'b1, 1'b0, 1'b0, "post_rst_accept");
        exp_rng(71, 74, 1'b1, 1'b0, "post_rst_high");
    end

endmodule
